button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_pkg.sv | 13 +
 rtl/sync_2ff.sv | 24 ++
 rtl/button_debounce.sv | 127 ++++++++++++
 tb/tb_button_debounce.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// button_pkg: shared FSM state encoding and synchronizer depth for button input stages
package button_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: reusable flop-chain synchronizer for asynchronous inputs, depth from button_pkg
module sync_2ff
   import button_pkg::*;
#(
   parameter int               Width    = 1,
   parameter logic [Width-1:0] ResetVal = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] i_d,
   output logic [Width-1:0] o_q
);

   logic [SYNC_STAGES-1:0][Width-1:0] r_sync;

   // shift the raw input through the chain; reset loads the idle value so no edge is seen on release
   always_ff @(posedge clk) begin
      if (!rst_n) r_sync <= {SYNC_STAGES{ResetVal}};
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
   end

   assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// button_debounce: active-low pushbutton debouncer with press/release strobes; long-press strobe under BUTTON_DEBOUNCE_LONGPRESS_EN
module button_debounce
   import button_pkg::*;
#(
   parameter int DebounceCycles = 1000,
   parameter int LongCycles     = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int              CntW    = $clog2(DebounceCycles);
   localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

   logic            w_sync_n;
   logic            w_sync_p;
   logic            w_accept_press;
   logic            w_accept_release;
   state_t          r_state;
   logic [CntW-1:0] r_cnt;
   logic            r_level;
   logic            r_press;
   logic            r_release;

   sync_2ff #(.Width(1), .ResetVal(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (button),
      .o_q   (w_sync_n)
   );

   assign w_sync_p         = ~w_sync_n;
   assign w_accept_press   = (r_state == PRESS_WAIT)   &&  w_sync_p && (r_cnt == CntLast);
   assign w_accept_release = (r_state == RELEASE_WAIT) && !w_sync_p && (r_cnt == CntLast);

   // debounce FSM: a level change is accepted only after DebounceCycles consecutive agreeing samples
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= RELEASED;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_press   <= w_accept_press;
         r_release <= w_accept_release;
         case (r_state)
            RELEASED: if (w_sync_p) begin
               r_state <= PRESS_WAIT;
               r_cnt   <= '0;
            end
            PRESS_WAIT: if (!w_sync_p) begin
               r_state <= RELEASED;
               r_cnt   <= '0;
            end else if (w_accept_press) begin
               r_state <= PRESSED;
               r_cnt   <= '0;
               r_level <= 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
            PRESSED: if (!w_sync_p) begin
               r_state <= RELEASE_WAIT;
               r_cnt   <= '0;
            end
            RELEASE_WAIT: if (w_sync_p) begin
               r_state <= PRESSED;
               r_cnt   <= '0;
            end else if (w_accept_release) begin
               r_state <= RELEASED;
               r_cnt   <= '0;
               r_level <= 1'b0;
            end else r_cnt <= r_cnt + 1'b1;
            default: begin
               r_state <= RELEASED;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign level         = r_level;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
   localparam int              HoldW    = $clog2(LongCycles);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(LongCycles - 1);

   logic             w_holding;
   logic [HoldW-1:0] r_hold;
   logic             r_long_done;
   logic             r_long;

   assign w_holding = (r_state == PRESSED) || (r_state == RELEASE_WAIT);

   // hold timer restarts only on a freshly accepted press; bounce-returns keep counting, one strobe per press
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hold      <= '0;
         r_long_done <= 1'b0;
         r_long      <= 1'b0;
      end else begin
         r_long <= 1'b0;
         if (w_accept_press) begin
            r_hold      <= '0;
            r_long_done <= 1'b0;
         end else if (w_holding) begin
            if (r_hold != HoldLast) r_hold <= r_hold + 1'b1;
            else if (!r_long_done && !w_accept_release) begin
               r_long      <= 1'b1;
               r_long_done <= 1'b1;
            end
         end
      end
   end

   assign long_pulse = r_long;
`else
   // constant zero; the comparison only keeps LongCycles referenced in this build
   assign long_pulse = 1'b0 & (LongCycles > DebounceCycles);
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed checks of debounce timing, bounce rejection, long press and reset
module tb_button_debounce;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
   localparam int LongExp = 1;
`else
   localparam int LongExp = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic button;
   logic level;
   logic press_pulse;
   logic release_pulse;
   logic long_pulse;

   int n_cmp = 0;
   int n_err = 0;
   int n_press = 0;
   int n_release = 0;
   int n_long = 0;
   int n_multi = 0;

   button_debounce #(.DebounceCycles(4), .LongCycles(20)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .button        (button),
      .level         (level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         n_press   += int'(press_pulse);
         n_release += int'(release_pulse);
         n_long    += int'(long_pulse);
         if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) > 1) n_multi++;
      end
   endtask

   task automatic clr();
      n_press   = 0;
      n_release = 0;
      n_long    = 0;
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      button = 1'b0;
      cyc(5);
      chk("rst_level", int'(level), 0);
      chk("rst_outs", int'(press_pulse) + int'(release_pulse) + int'(long_pulse), 0);
      rst_n  = 1'b1;
      button = 1'b1;
      clr();
      cyc(50);
      chk("idle_level", int'(level), 0);
      chk("idle_pulses", n_press + n_release + n_long, 0);

      clr();
      button = 1'b0;
      cyc(6);
      chk("press_e6_none", n_press, 0);
      chk("press_e6_level", int'(level), 0);
      cyc(1);
      chk("press_e7_pulse", int'(press_pulse), 1);
      chk("press_e7_level", int'(level), 1);
      cyc(1);
      chk("press_e8_pulse", int'(press_pulse), 0);
      chk("press_once", n_press, 1);
      cyc(18);
      chk("long_e26_none", n_long, 0);
      cyc(1);
      chk("long_e27_pulse", int'(long_pulse), LongExp);
      cyc(13);
      chk("long_once", n_long, LongExp);
      chk("hold_press_once", n_press, 1);
      chk("hold_level", int'(level), 1);

      clr();
      button = 1'b1;
      cyc(6);
      chk("rel_e6_none", n_release, 0);
      chk("rel_e6_level", int'(level), 1);
      cyc(1);
      chk("rel_e7_pulse", int'(release_pulse), 1);
      chk("rel_e7_level", int'(level), 0);
      cyc(5);
      chk("rel_once", n_release, 1);
      chk("rel_no_press", n_press + n_long, 0);

      clr();
      button = 1'b0;
      cyc(3);
      button = 1'b1;
      cyc(20);
      chk("glitch_level", int'(level), 0);
      chk("glitch_press", n_press, 0);
      chk("glitch_release", n_release, 0);

      clr();
      button = 1'b0;
      cyc(7);
      chk("bounce_accept", n_press, 1);
      button = 1'b1;
      cyc(2);
      button = 1'b0;
      cyc(20);
      chk("bounce_no_release", n_release, 0);
      chk("bounce_level", int'(level), 1);
      button = 1'b1;
      cyc(12);
      chk("bounce_final_release", n_release, 1);
      chk("bounce_final_level", int'(level), 0);

      clr();
      button = 1'b0;
      cyc(4);
      rst_n = 1'b0;
      cyc(2);
      chk("midrst_level", int'(level), 0);
      rst_n = 1'b1;
      cyc(6);
      chk("midrst_no_press", n_press, 0);
      cyc(1);
      chk("midrst_fresh_press", int'(press_pulse), 1);
      chk("midrst_fresh_level", int'(level), 1);

      chk("pulses_exclusive", n_multi, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
